// File: rtl/lab3_pkg.sv
// Shared types and constants for the lab3 traffic-light controller:
// phase enum, LED bit positions, lamp codes and the phase-timer width.
package lab3_pkg;

  localparam int TMR_W = 16;

  typedef enum logic [2:0] {
    MG,
    MY,
    AR1,
    SG,
    SY,
    AR2
  } state_e;

  localparam int LED_MAIN_G = 0;
  localparam int LED_MAIN_Y = 1;
  localparam int LED_MAIN_R = 2;
  localparam int LED_SIDE_G = 3;
  localparam int LED_SIDE_Y = 4;
  localparam int LED_SIDE_R = 5;
  localparam int LED_WALK   = 6;
  localparam int LED_REQ    = 7;

  localparam logic [7:0] LAMP_MG = 8'((1 << LED_MAIN_G) | (1 << LED_SIDE_R));
  localparam logic [7:0] LAMP_MY = 8'((1 << LED_MAIN_Y) | (1 << LED_SIDE_R));
  localparam logic [7:0] LAMP_AR = 8'((1 << LED_MAIN_R) | (1 << LED_SIDE_R));
  localparam logic [7:0] LAMP_SG = 8'((1 << LED_SIDE_G) | (1 << LED_MAIN_R));
  localparam logic [7:0] LAMP_SY = 8'((1 << LED_SIDE_Y) | (1 << LED_MAIN_R));

  function automatic state_e next_state(input state_e s);
    case (s)
      MG:      next_state = MY;
      MY:      next_state = AR1;
      AR1:     next_state = SG;
      SG:      next_state = SY;
      SY:      next_state = AR2;
      default: next_state = MG;
    endcase
  endfunction

  function automatic logic [7:0] lamp_code(input state_e s);
    case (s)
      MG:      lamp_code = LAMP_MG;
      MY:      lamp_code = LAMP_MY;
      SG:      lamp_code = LAMP_SG;
      SY:      lamp_code = LAMP_SY;
      default: lamp_code = LAMP_AR;
    endcase
  endfunction

endpackage

// File: rtl/lab3_btn_cond.sv
// Pedestrian button conditioning: 2-flop synchronizer, optional debouncer
// (enabled by LAB3_BTN_DEBOUNCE_EN) and a one-cycle rising-edge pulse.
module lab3_btn_cond
  import lab3_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);

  logic sync1_q;
  logic btn_s_q;
  logic lvl;
  logic lvl_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      btn_s_q <= sync1_q;
    end
  end

`ifdef LAB3_BTN_DEBOUNCE_EN
  localparam logic [TMR_W-1:0] DB_LAST = TMR_W'(DEBOUNCE_CYC - 1);

  logic             lvl_q;
  logic [TMR_W-1:0] db_cnt_q;

  // The counter tracks how long btn_s has disagreed with the accepted level;
  // any return to agreement restarts the count, so short glitches never land.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvl_q    <= 1'b0;
      db_cnt_q <= '0;
    end else if (btn_s_q != lvl_q) begin
      if (db_cnt_q == DB_LAST) begin
        lvl_q    <= btn_s_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + TMR_W'(1);
      end
    end else begin
      db_cnt_q <= '0;
    end
  end

  assign lvl = lvl_q;
`else
  localparam int unsigned unused_debounce_cyc = DEBOUNCE_CYC;

  assign lvl = btn_s_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvl_prev_q <= 1'b0;
    end else begin
      lvl_prev_q <= lvl;
    end
  end

  assign rise_o = lvl & ~lvl_prev_q;

endmodule

// File: rtl/lab3_traffic_light.sv
// Two-road traffic-light controller with pedestrian request and WALK lamp.
// Define LAB3_BTN_DEBOUNCE_EN to debounce the button before edge detection.
module lab3_traffic_light
  import lab3_pkg::*;
#(
  parameter int unsigned MAIN_GREEN_CYC = 40,
  parameter int unsigned MIN_GREEN_CYC  = 8,
  parameter int unsigned SIDE_GREEN_CYC = 20,
  parameter int unsigned YELLOW_CYC     = 6,
  parameter int unsigned ALL_RED_CYC    = 2,
  parameter int unsigned DEBOUNCE_CYC   = 4
) (
  input  logic       sys_clkp,
  input  logic       sys_clkn,
  input  logic       sys_rst_n,
  input  logic       button,
  output logic [7:0] led
);

  // Timer value at or below which MIN_GREEN_CYC cycles of MG have elapsed.
  localparam logic [TMR_W-1:0] MG_CUT = (MIN_GREEN_CYC >= MAIN_GREEN_CYC) ?
                                        '0 : TMR_W'(MAIN_GREEN_CYC - MIN_GREEN_CYC);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             req_q, req_d;
  logic             walk_q, walk_d;
  logic [7:0]       led_q, led_d;
  logic             advance;
  logic             btn_rise;
  logic             unused_clkn;

  assign unused_clkn = sys_clkn;

  function automatic logic [TMR_W-1:0] dwell_load(input state_e s);
    case (s)
      MG:      dwell_load = TMR_W'(MAIN_GREEN_CYC - 1);
      MY, SY:  dwell_load = TMR_W'(YELLOW_CYC - 1);
      SG:      dwell_load = TMR_W'(SIDE_GREEN_CYC - 1);
      default: dwell_load = TMR_W'(ALL_RED_CYC - 1);
    endcase
  endfunction

  lab3_btn_cond #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn_cond (
    .clk_i  (sys_clkp),
    .rst_ni (sys_rst_n),
    .btn_i  (button),
    .rise_o (btn_rise)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q - TMR_W'(1);
    req_d   = req_q;
    walk_d  = walk_q;
    advance = (timer_q == '0);
    if (state_q == MG && req_q && timer_q <= MG_CUT) begin
      advance = 1'b1;
    end

    if (advance) begin
      state_d = next_state(state_q);
      timer_d = dwell_load(state_d);
      if (state_d == SG) begin
        walk_d = req_q;
        req_d  = 1'b0;
      end else if (state_q == SG) begin
        walk_d = 1'b0;
      end
    end

    // A new press beats the SG-entry clear so it is never lost.
    if (btn_rise) begin
      req_d = 1'b1;
    end

    // The LED register is loaded from next-state values so lamps change on
    // the same edge as the phase and request flags.
    led_d           = lamp_code(state_d);
    led_d[LED_WALK] = led_d[LED_WALK] | walk_d;
    led_d[LED_REQ]  = led_d[LED_REQ] | req_d;
  end

  always_ff @(posedge sys_clkp or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= AR2;
      timer_q <= TMR_W'(ALL_RED_CYC - 1);
      req_q   <= 1'b0;
      walk_q  <= 1'b0;
      led_q   <= LAMP_AR;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      walk_q  <= walk_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_lab3_traffic_light.sv
// Scoreboard bench for lab3_traffic_light: each scenario queues the expected
// per-cycle LED pattern and compares it against the DUT one cycle at a time.
module tb_lab3_traffic_light;

`ifdef LAB3_BTN_DEBOUNCE_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  logic       clk_p;
  logic       clk_n;
  logic       rst_n;
  logic       button;
  logic [7:0] led;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  lab3_traffic_light dut (
    .sys_clkp  (clk_p),
    .sys_clkn  (clk_n),
    .sys_rst_n (rst_n),
    .button    (button),
    .led       (led)
  );

  initial clk_p = 1'b0;
  always #5 clk_p = ~clk_p;
  assign clk_n = ~clk_p;

  task automatic push(input logic [7:0] v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(v);
  endtask

  task automatic tick(output logic [7:0] got);
    @(negedge clk_p);
    got = led;
  endtask

  task automatic push_period_no_req();
    push(8'h21, 40); push(8'h22, 6); push(8'h24, 2);
    push(8'h0C, 20); push(8'h14, 6); push(8'h24, 2);
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    int i;
    rst_n = 1'b1;
    button = 1'b0;
    #12;
    rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 8'h24) begin
      errors++;
      $display("FAIL reset_async: led=%h expected %h", led, 8'h24);
    end
    repeat (2) @(negedge clk_p);
    checks++;
    if (led !== 8'h24) begin
      errors++;
      $display("FAIL reset_hold: led=%h expected %h", led, 8'h24);
    end
    rst_n = 1'b1;
    push(8'h24, 1);
    push(8'h21, 1);
    i = 0;
    while (exp_q.size() > 0) begin
      tick(got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_release cycle %0d: led=%h expected %h", i, got, exp);
      end
      i++;
    end
  endtask

  task automatic test_no_press();
    logic [7:0] got, exp;
    int i;
    push(8'h21, 39); push(8'h22, 6); push(8'h24, 2);
    push(8'h0C, 20); push(8'h14, 6); push(8'h24, 2);
    push_period_no_req();
    i = 0;
    while (exp_q.size() > 0) begin
      tick(got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL no_press cycle %0d: led=%h expected %h", i, got, exp);
      end
      i++;
    end
  endtask

  task automatic test_press_in_mg();
    logic [7:0] got, exp;
    int i, vis, mg_len;
    vis = 2 + LAT;
    mg_len = (vis > 8) ? vis : 8;
    push(8'h21, vis - 1); push(8'hA1, mg_len - vis + 1);
    push(8'hA2, 6); push(8'hA4, 2);
    push(8'h4C, 20); push(8'h14, 6); push(8'h24, 2);
    i = 0;
    while (exp_q.size() > 0) begin
      tick(got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL press_in_mg cycle %0d: led=%h expected %h", i, got, exp);
      end
      button = (i >= 1 && i < 31);
      i++;
    end
    button = 1'b0;
  endtask

  task automatic test_press_in_sg();
    logic [7:0] got, exp;
    int i;
    push(8'h21, 40); push(8'h22, 6); push(8'h24, 2);
    push(8'h0C, 4 + LAT); push(8'h8C, 20 - (4 + LAT));
    push(8'h94, 6); push(8'hA4, 2);
    push(8'hA1, 8); push(8'hA2, 6); push(8'hA4, 2);
    push(8'h4C, 20); push(8'h14, 6); push(8'h24, 2);
    i = 0;
    while (exp_q.size() > 0) begin
      tick(got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL press_in_sg cycle %0d: led=%h expected %h", i, got, exp);
      end
      button = (i >= 52 && i < 58);
      i++;
    end
    button = 1'b0;
  endtask

  // Second press lands its edge on the SG-entry cycle while a request is held.
  task automatic test_back_to_back();
    logic [7:0] got, exp;
    int i, vis, mg_len, s1;
    vis = 2 + LAT;
    mg_len = (vis > 8) ? vis : 8;
    s1 = mg_len + 8 - LAT;
    push(8'h21, vis - 1); push(8'hA1, mg_len - vis + 1);
    push(8'hA2, 6); push(8'hA4, 2);
    push(8'hCC, 20); push(8'h94, 6); push(8'hA4, 2);
    push(8'hA1, 8); push(8'hA2, 6); push(8'hA4, 2);
    push(8'h4C, 20); push(8'h14, 6); push(8'h24, 2);
    i = 0;
    while (exp_q.size() > 0) begin
      tick(got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: led=%h expected %h", i, got, exp);
      end
      button = (i >= 1 && i < 5) || (i >= s1 && i < s1 + 6);
      i++;
    end
    button = 1'b0;
  endtask

  task automatic test_reset_mid_sy();
    logic [7:0] got, exp;
    int i;
    push(8'h21, 40); push(8'h22, 6); push(8'h24, 2);
    push(8'h0C, 20); push(8'h14, 3);
    i = 0;
    while (exp_q.size() > 0) begin
      tick(got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pre_reset_sy cycle %0d: led=%h expected %h", i, got, exp);
      end
      i++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 8'h24) begin
      errors++;
      $display("FAIL reset_mid_sy_async: led=%h expected %h", led, 8'h24);
    end
    @(negedge clk_p);
    checks++;
    if (led !== 8'h24) begin
      errors++;
      $display("FAIL reset_mid_sy_hold: led=%h expected %h", led, 8'h24);
    end
    rst_n = 1'b1;
    push(8'h24, 1); push(8'h21, 40); push(8'h22, 1);
    i = 0;
    while (exp_q.size() > 0) begin
      tick(got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL restart_after_sy cycle %0d: led=%h expected %h", i, got, exp);
      end
      i++;
    end
  endtask

  task automatic test_glitch();
    logic [7:0] got, exp;
    int i;
    rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 8'h24) begin
      errors++;
      $display("FAIL glitch_reset: led=%h expected %h", led, 8'h24);
    end
    @(negedge clk_p);
    rst_n = 1'b1;
    push(8'h24, 1);
`ifdef LAB3_BTN_DEBOUNCE_EN
    push_period_no_req();
`else
    push(8'h21, 4); push(8'hA1, 4); push(8'hA2, 6); push(8'hA4, 2);
    push(8'h4C, 20); push(8'h14, 6); push(8'h24, 2);
`endif
    i = 0;
    while (exp_q.size() > 0) begin
      tick(got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL glitch cycle %0d: led=%h expected %h", i, got, exp);
      end
      button = (i >= 2 && i < 4);
      i++;
    end
    button = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    button = 1'b0;
    test_reset();
    test_no_press();
    test_press_in_mg();
    test_press_in_sg();
    test_back_to_back();
    test_reset_mid_sy();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit reached");
  end

endmodule
